// File: rtl/grid_pkg.sv
`default_nettype none
// grid_pkg: shared sizes, cell indexing, scan state encoding and a row popcount helper.
// Revision 1.0 - initial release.
package grid_pkg;

  localparam int GRID_N = 8;
  localparam int CELLS  = 64;
  localparam int POP_W  = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    GAP  = 2'd2
  } scan_state_t;

  // r*8+c, returned at the exact width of a 64-cell index
  function automatic logic [5:0] idx(input logic [2:0] r, input logic [2:0] c);
    return {r, c};
  endfunction

  function automatic logic [3:0] popcnt8(input logic [7:0] b);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, b[i]};
    end
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/grid_popcount_seq.sv
`default_nettype none
// grid_popcount_seq: counts live cells one row per cycle; count and done arrive 8 cycles after start.
// Revision 1.0 - initial release.
module grid_popcount_seq
  import grid_pkg::*;
(
  input  logic             clk,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [CELLS-1:0] grid_i,
  output logic [POP_W-1:0] count_o,
  output logic             done_o
);

  logic             busy_q, busy_d;
  logic [2:0]       row_q, row_d;
  logic [2:0]       rd_row;
  logic [POP_W-1:0] acc_q, acc_d;
  logic [POP_W-1:0] count_q, count_d;
  logic [POP_W-1:0] sum;
  logic             done_q, done_d;

  // grid_i must stay stable for the 8 counting cycles; the caller guarantees it
  always_comb begin
    rd_row  = start_i ? 3'd0 : row_q;
    sum     = (start_i ? {POP_W{1'b0}} : acc_q)
            + POP_W'(popcnt8(grid_i[idx(rd_row, 3'd0) +: GRID_N]));
    busy_d  = busy_q;
    row_d   = row_q;
    acc_d   = acc_q;
    count_d = count_q;
    done_d  = 1'b0;
    if (start_i) begin
      busy_d = 1'b1;
      row_d  = 3'd1;
      acc_d  = sum;
    end else if (busy_q) begin
      if (row_q == 3'd7) begin
        busy_d  = 1'b0;
        count_d = sum;
        done_d  = 1'b1;
      end else begin
        row_d = row_q + 3'd1;
        acc_d = sum;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      busy_q  <= 1'b0;
      row_q   <= 3'd0;
      acc_q   <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      row_q   <= row_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  assign count_o = count_q;
  assign done_o  = done_q;

endmodule
`default_nettype wire

// File: rtl/grid_scan_driver.sv
`default_nettype none
// grid_scan_driver: double-buffered 8x8 generation, row-multiplexed with dwell and blanking.
// Revision 1.0 - initial release.
module grid_scan_driver
  import grid_pkg::*;
#(
  parameter int DWELL_CYC      = 1000,
  parameter int BLANK_CYC      = 16,
  parameter int ROW_ACTIVE_LOW = 0
) (
  input  logic              clk,
  input  logic              _rst,
  input  logic [CELLS-1:0]  grid_in,
  input  logic              grid_valid,
  output logic              grid_ready,
  output logic [GRID_N-1:0] row_sel,
  output logic [GRID_N-1:0] col_data,
  output logic              frame_done,
  output logic [POP_W-1:0]  pop_count,
  output logic              pop_valid
);

  localparam int MAXC = (DWELL_CYC > BLANK_CYC) ? DWELL_CYC : BLANK_CYC;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYC - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
  localparam logic [GRID_N-1:0] ROW_OFF = (ROW_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

  scan_state_t      state_q, state_d;
  logic [2:0]       row_q, row_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CELLS-1:0] pend_q, pend_d;
  logic             pend_full_q, pend_full_d;
  logic [CELLS-1:0] active_q, active_d;
  logic             ready_q, ready_d;
  logic             pop_start_q;
  logic             promote, frame_end, row_end, xfer;
  logic [GRID_N-1:0] row_sel_q, row_sel_d, row_pin_d;
  logic [GRID_N-1:0] col_q, col_d;
  logic              frame_done_q, frame_done_d;

  always_ff @(posedge clk) begin
    if (_rst) begin
      state_q      <= IDLE;
      row_q        <= 3'd0;
      cnt_q        <= '0;
      pend_q       <= '0;
      pend_full_q  <= 1'b0;
      active_q     <= '0;
      ready_q      <= 1'b0;
      pop_start_q  <= 1'b0;
      row_sel_q    <= ROW_OFF;
      col_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      cnt_q        <= cnt_d;
      pend_q       <= pend_d;
      pend_full_q  <= pend_full_d;
      active_q     <= active_d;
      ready_q      <= ready_d;
      pop_start_q  <= promote;
      row_sel_q    <= row_pin_d;
      col_q        <= col_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    cnt_d     = cnt_q;
    promote   = 1'b0;
    frame_end = 1'b0;
    row_end   = 1'b0;
    case (state_q)
      IDLE: begin
        if (pend_full_q) begin
          promote = 1'b1;
          state_d = SCAN;
          row_d   = 3'd0;
          cnt_d   = '0;
        end
      end
      SCAN: begin
        if (cnt_q == DWELL_LAST) begin
          cnt_d = '0;
          if (BLANK_CYC > 0) state_d = GAP;
          else               row_end = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      GAP: begin
        if (cnt_q == BLANK_LAST) begin
          cnt_d   = '0;
          row_end = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // A frame always restarts at row 0; only whether a new generation is swapped in differs
    if (row_end) begin
      state_d = SCAN;
      row_d   = row_q + 3'd1;
      if (row_q == 3'd7) begin
        frame_end = 1'b1;
        promote   = pend_full_q;
      end
    end

    // ready mirrors !full, so a transfer and a promotion can never coincide
    xfer        = grid_valid && ready_q;
    active_d    = promote ? pend_q : active_q;
    pend_d      = xfer ? grid_in : pend_q;
    pend_full_d = xfer ? 1'b1 : (promote ? 1'b0 : pend_full_q);
    ready_d     = !pend_full_d;
  end

  always_comb begin
    row_sel_d    = '0;
    col_d        = '0;
    frame_done_d = frame_end;
    if (state_q == SCAN) begin
      row_sel_d = GRID_N'(1) << row_q;
      col_d     = active_q[idx(row_q, 3'd0) +: GRID_N];
    end
  end

  generate
    if (ROW_ACTIVE_LOW != 0) begin : g_row_active_low
      assign row_pin_d = ~row_sel_d;
    end else begin : g_row_active_high
      assign row_pin_d = row_sel_d;
    end
  endgenerate

  grid_popcount_seq u_popcount (
    .clk     (clk),
    .rst_i   (_rst),
    .start_i (pop_start_q),
    .grid_i  (active_q),
    .count_o (pop_count),
    .done_o  (pop_valid)
  );

  assign grid_ready = ready_q;
  assign row_sel    = row_sel_q;
  assign col_data   = col_q;
  assign frame_done = frame_done_q;

endmodule
`default_nettype wire
